// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared render pipeline types and constants
package render_pkg;

   localparam int VERTEX_COORDS = 3;

   typedef enum logic [1:0] {
      VERTEX_FETCH_IDLE,
      VERTEX_FETCH_FETCH,
      VERTEX_FETCH_DRAIN,
      VERTEX_FETCH_DONE
   } vertex_fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered head-of-queue read data
module sync_fifo #(
   parameter int WIDTH = 54,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign empty  = (count == '0);
   assign do_pop = pop && !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // rdata always shows the current head, so it is refreshed whenever the head changes
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (do_pop && (count > CW'(1))) begin
            rdata <= mem[rd_ptr + 1'b1];
         end else if (push && ((count == '0) || (do_pop && (count == CW'(1))))) begin
            rdata <= wdata;
         end
      end
   end

endmodule

// File: rtl/vertex_fetch.sv
// rtl/vertex_fetch.sv - credit-limited vertex fetch from BRAM into the vertex shader input
module vertex_fetch
   import render_pkg::*;
#(
   parameter int DATAWIDTH   = 18,
   parameter int ADDRWIDTH   = 12,
   parameter int MEM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic [ADDRWIDTH-1:0]        i_base_addr,
   input  logic [ADDRWIDTH:0]          i_num_vertices,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_mem_re,
   output logic [ADDRWIDTH-1:0]        o_mem_addr,
   input  logic [3*DATAWIDTH-1:0]      i_mem_data,
   input  logic                        i_ready,
   output logic signed [DATAWIDTH-1:0] o_vertex [VERTEX_COORDS],
   output logic                        o_dv,
   output logic                        o_last
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(MEM_LATENCY + 1);

   vertex_fetch_state_t state, state_next;

   logic [ADDRWIDTH:0]       num_reg;
   logic [ADDRWIDTH:0]       issued;
   logic [ADDRWIDTH:0]       xfers;
   logic [MEM_LATENCY-1:0]   vsr;
   logic [IW-1:0]            inflight;
   logic [CW-1:0]            fifo_count;
   logic                     fifo_empty;
   logic [3*DATAWIDTH-1:0]   fifo_rdata;
   logic                     credit_ok;
   logic                     last_issue;
   logic                     last_xfer;
   logic                     xfer;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + IW'(vsr[i]);
      end
   end

   // A read is only issued when the FIFO is guaranteed room for it on return
   assign credit_ok  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
   assign o_mem_re   = (state == VERTEX_FETCH_FETCH) && credit_ok;
   assign last_issue = ((issued + 1'b1) == num_reg);
   assign o_dv       = !fifo_empty;
   assign xfer       = o_dv && i_ready;
   assign last_xfer  = ((xfers + 1'b1) == num_reg);
   assign o_last     = o_dv && last_xfer;

   always_comb begin
      state_next = state;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      unique case (state)
         VERTEX_FETCH_IDLE: begin
            if (i_start) begin
               state_next = (i_num_vertices == '0) ? VERTEX_FETCH_DONE : VERTEX_FETCH_FETCH;
            end
         end
         VERTEX_FETCH_FETCH: begin
            o_busy = 1'b1;
            if (o_mem_re && last_issue) begin
               state_next = VERTEX_FETCH_DRAIN;
            end
         end
         VERTEX_FETCH_DRAIN: begin
            o_busy = 1'b1;
            if (xfer && last_xfer) begin
               state_next = VERTEX_FETCH_DONE;
            end
         end
         VERTEX_FETCH_DONE: begin
            o_done     = 1'b1;
            state_next = VERTEX_FETCH_IDLE;
         end
         default: state_next = VERTEX_FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= VERTEX_FETCH_IDLE;
         o_mem_addr <= '0;
         num_reg    <= '0;
         issued     <= '0;
         xfers      <= '0;
         vsr        <= '0;
      end else begin
         state <= state_next;
         vsr   <= (vsr << 1) | MEM_LATENCY'(o_mem_re);
         if ((state == VERTEX_FETCH_IDLE) && i_start) begin
            o_mem_addr <= i_base_addr;
            num_reg    <= i_num_vertices;
            issued     <= '0;
            xfers      <= '0;
         end
         if (o_mem_re) begin
            o_mem_addr <= o_mem_addr + 1'b1;
            issued     <= issued + 1'b1;
         end
         if (xfer) begin
            xfers <= xfers + 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (3 * DATAWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vsr[MEM_LATENCY-1]),
      .pop   (xfer),
      .wdata (i_mem_data),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   // Memory word is packed {z,y,x}; x sits in the low bits
   always_comb begin
      for (int i = 0; i < VERTEX_COORDS; i++) begin
         o_vertex[i] = fifo_rdata[i*DATAWIDTH +: DATAWIDTH];
      end
   end

endmodule

// File: tb/tb_vertex_fetch.sv
// tb/tb_vertex_fetch.sv - self-checking bench for vertex_fetch
module tb_vertex_fetch;
   import render_pkg::*;

   localparam int DW = 18;
   localparam int AW = 12;
   localparam int ML = 2;
   localparam int FD = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 i_start;
   logic [AW-1:0]        i_base_addr;
   logic [AW:0]          i_num_vertices;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_mem_re;
   logic [AW-1:0]        o_mem_addr;
   logic [3*DW-1:0]      i_mem_data;
   logic                 i_ready;
   logic signed [DW-1:0] o_vertex [VERTEX_COORDS];
   logic                 o_dv;
   logic                 o_last;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vertex_fetch #(
      .DATAWIDTH   (DW),
      .ADDRWIDTH   (AW),
      .MEM_LATENCY (ML),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (i_start),
      .i_base_addr    (i_base_addr),
      .i_num_vertices (i_num_vertices),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_mem_re       (o_mem_re),
      .o_mem_addr     (o_mem_addr),
      .i_mem_data     (i_mem_data),
      .i_ready        (i_ready),
      .o_vertex       (o_vertex),
      .o_dv           (o_dv),
      .o_last         (o_last)
   );

   // Behavioural BRAM: mem[a] = {a+2, a+1, a}, fixed read latency ML
   logic [AW-1:0] rd_pipe [ML];

   function automatic logic [3*DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [DW-1:0] x;
      x = DW'(a);
      return {x + DW'(2), x + DW'(1), x};
   endfunction

   always @(posedge clk) begin
      rd_pipe[0] <= o_mem_addr;
      for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign i_mem_data = mem_word(rd_pipe[ML-1]);

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         0:       return 1'b1;
         1:       return ((c % 4) == 0) || ((c % 4) == 3);
         2:       return c > 20;
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   // One fetch run checked against plain arithmetic expectations; cycle 0 is the i_start cycle
   task automatic run(input int base, input int num, input int mode, input int spurious,
                      output int first_dv, output int done_cyc, output int reads20);
      int c, reads, xfers, done_cnt, last_xfer_c, x, exp_done;
      int err_addr, err_data, err_last, err_stable, err_cap, err_busy, err_done_t;
      logic prev_stall, prev_last, exp_busy;
      logic signed [DW-1:0] prev_v [VERTEX_COORDS];
      bit fin;
      reads = 0; xfers = 0; done_cnt = 0; last_xfer_c = -1;
      err_addr = 0; err_data = 0; err_last = 0; err_stable = 0;
      err_cap = 0; err_busy = 0; err_done_t = 0;
      first_dv = -1; done_cyc = -1; reads20 = 0;
      prev_stall = 1'b0; prev_last = 1'b0;
      for (int i = 0; i < VERTEX_COORDS; i++) prev_v[i] = '0;
      @(posedge clk); #1;
      c = 0; fin = 0;
      i_base_addr = AW'(base);
      i_num_vertices = (AW+1)'(num);
      i_start = 1'b1;
      i_ready = ready_for(mode, 0);
      while (!fin) begin
         @(negedge clk);
         if (o_mem_re) begin
            if (o_mem_addr != AW'((base + reads) % 4096)) err_addr++;
            reads++;
            if (c <= 20) reads20++;
         end
         if (reads - xfers > FD) err_cap++;
         if (prev_stall) begin
            if (!o_dv || (o_last != prev_last)) err_stable++;
            for (int i = 0; i < VERTEX_COORDS; i++)
               if (o_vertex[i] != prev_v[i]) err_stable++;
         end
         if (o_dv && first_dv < 0) first_dv = c;
         if (o_dv && (o_last != (xfers == num - 1))) err_last++;
         if (!o_dv && o_last) err_last++;
         if (o_dv && i_ready) begin
            x = (base + xfers) % 4096;
            if (o_vertex[0] != DW'(x) || o_vertex[1] != DW'(x + 1) || o_vertex[2] != DW'(x + 2))
               err_data++;
            xfers++;
            last_xfer_c = c;
         end
         if (o_done) begin
            done_cnt++;
            done_cyc = c;
            exp_done = (num == 0) ? 1 : last_xfer_c + 1;
            if (c != exp_done) err_done_t++;
         end
         exp_busy = (num != 0) && (c >= 1) && (done_cnt == 0);
         if (o_busy != exp_busy) err_busy++;
         prev_stall = o_dv && !i_ready;
         prev_last = o_last;
         for (int i = 0; i < VERTEX_COORDS; i++) prev_v[i] = o_vertex[i];
         if (done_cnt > 0 || c >= 300) begin
            fin = 1;
         end else begin
            @(posedge clk); #1;
            c++;
            i_start = (spurious != 0) && (c == 3);
            if (i_start) begin
               i_base_addr = AW'(2000);
               i_num_vertices = (AW+1)'(7);
            end
            i_ready = ready_for(mode, c);
         end
      end
      i_start = 1'b0;
      check("reads_issued", reads, num);
      check("vertices_transferred", xfers, num);
      check("done_pulses", done_cnt, 1);
      check("addr_errors", err_addr, 0);
      check("data_errors", err_data, 0);
      check("last_errors", err_last, 0);
      check("stall_stability_errors", err_stable, 0);
      check("credit_overrun_cycles", err_cap, 0);
      check("busy_errors", err_busy, 0);
      check("done_timing_errors", err_done_t, 0);
   endtask

   typedef struct {
      int base;
      int num;
      int mode;
      int spurious;
      int exp_first_dv;
      int exp_done;
      int exp_reads20;
   } vec_t;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      int fd, dc, r20, base, num, sp;

      // -2 means the field is not checked for that vector
      vecs.push_back('{10,   5, 0, 0,  4,  9,  5});
      vecs.push_back('{10,   5, 1, 0,  4, -2, -2});
      vecs.push_back('{4094, 4, 0, 0,  4,  8,  4});
      vecs.push_back('{77,   0, 0, 0, -1,  1,  0});
      vecs.push_back('{300,  8, 2, 0,  4, 29,  4});
      vecs.push_back('{50,   1, 0, 1,  4,  5,  1});
      vecs.push_back('{4095, 3, 1, 1,  4, -2, -2});

      rst = 1'b1; i_start = 1'b0; i_ready = 1'b0;
      i_base_addr = '0; i_num_vertices = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
      check("reset_mem_re", o_mem_re, 0);
      check("reset_mem_addr", o_mem_addr, 0);
      check("reset_dv", o_dv, 0);
      check("reset_last", o_last, 0);
      check("reset_vertex", {o_vertex[2], o_vertex[1], o_vertex[0]}, 0);
      @(posedge clk); #1 rst = 1'b0;

      foreach (vecs[k]) begin
         run(vecs[k].base, vecs[k].num, vecs[k].mode, vecs[k].spurious, fd, dc, r20);
         if (vecs[k].exp_first_dv != -2) check($sformatf("vec%0d_first_dv_cycle", k), fd, vecs[k].exp_first_dv);
         if (vecs[k].exp_done != -2) check($sformatf("vec%0d_done_cycle", k), dc, vecs[k].exp_done);
         if (vecs[k].exp_reads20 != -2) check($sformatf("vec%0d_reads_by_cycle20", k), r20, vecs[k].exp_reads20);
      end

      // Reset in cycle 5 of a 10-vertex run, new run from cycle 8
      @(posedge clk); #1;
      i_base_addr = AW'(100); i_num_vertices = (AW+1)'(10); i_start = 1'b1; i_ready = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         i_start = 1'b0;
         if (c == 5) rst = 1'b1;
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rstmid_ctrl_outputs", {o_busy, o_done, o_mem_re, o_dv, o_last}, 0);
      check("rstmid_mem_addr", o_mem_addr, 0);
      check("rstmid_vertex", {o_vertex[2], o_vertex[1], o_vertex[0]}, 0);
      @(negedge clk);
      check("rstmid_c7_dv_done", {o_dv, o_done}, 0);
      run(0, 2, 0, 0, fd, dc, r20);
      check("rstmid_rerun_first_dv", fd, 4);
      check("rstmid_rerun_done", dc, 6);

      // Randomized runs against the arithmetic model in run()
      for (int k = 0; k < 12; k++) begin
         base = (k % 3 == 0) ? 4090 + int'($urandom_range(0, 5)) : int'($urandom_range(0, 4095));
         num = int'($urandom_range(0, 20));
         sp = (num > 0) ? int'($urandom_range(0, 1)) : 0;
         run(base, num, 3, sp, fd, dc, r20);
         check($sformatf("rand%0d_first_dv_cycle", k), fd, (num == 0) ? -1 : 4);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
